wiscv_proc: RTL and testbench

- Single-cycle RV32I processor core with its own instruction and data memories. It is the top-level DUT of the wiscv system bench.
- The bench preloads both memories with the same hex image, so the program's .data section is visible in data memory.
- The bench checks architectural state through fixed internal probe names, one instruction retired per clock.

---
 rtl/wiscv_pkg.sv | 66 ++++++
 rtl/wiscv_mem.sv | 29 ++
 rtl/wiscv_proc.sv | 177 +++++++++++++++++
 tb/tb_wiscv_proc.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/wiscv_pkg.sv
// wiscv_pkg: shared RV32I decode constants and the ALU operation set.
// Provides opcode/funct3 encodings, alu_op_e, and the ALU evaluation function.
package wiscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  function automatic logic [31:0] alu_eval(alu_op_e op, logic [31:0] a, logic [31:0] b);
    logic [31:0] y;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << b[4:0];
      ALU_SLT:    y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:   y = {31'b0, a < b};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> b[4:0];
      ALU_SRA:    y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_PASS_B: y = b;
      default:    y = '0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/wiscv_mem.sv
// wiscv_mem: word-organised memory with asynchronous read and byte-enabled
// synchronous write.
//   clk   - write clock
//   addr  - word index
//   be    - per-byte write enables (all zero = no write)
//   wdata - write data, lane-aligned
//   rdata - combinational read of mem[addr]
module wiscv_mem #(
  parameter int unsigned MEM_WORDS = 4096,
  localparam int unsigned AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:MEM_WORDS-1];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/wiscv_proc.sv
// wiscv_proc: single-cycle RV32I core with private instruction and data memories.
//   clk - system clock, all state updates on the rising edge
//   rst - synchronous active-high reset (pc, gprs, halt; memories retained)
// Architectural state and per-instruction activity are exposed as internal
// probe signals (gprs, pc, ecall, rf_wr_*, dmem_*, branch_taken, target_pc).
module wiscv_proc #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int unsigned MEM_WORDS    = 4096
) (
  input logic clk,
  input logic rst
);
  import wiscv_pkg::*;

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [31:0] gprs [0:31];
  logic [31:0] pc;
  logic        halted;

  logic        ecall, rf_wr_en, dmem_en, dmem_rd_wr, dmem_ready, branch_taken;
  logic [31:0] rf_wr_data, dmem_addr, dmem_wdata, target_pc;
  logic [4:0]  rf_wr_addr;

  logic [31:0] instr, mem_rdata;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_val, rs2_val, pc4;

  logic        legal, wr_rd, is_load, is_store, take, ecall_instr, exec;
  logic [1:0]  wb_sel;
  alu_op_e     alu_op;
  logic [31:0] alu_a, alu_b, alu_y, jump_tgt, wb_data, load_val, st_data;
  logic [3:0]  st_be;

  wiscv_mem #(.MEM_WORDS(MEM_WORDS)) u_instr_mem (
    .clk(clk), .addr(pc[AW+1:2]), .be('0), .wdata('0), .rdata(instr)
  );

  wiscv_mem #(.MEM_WORDS(MEM_WORDS)) u_data_mem (
    .clk(clk), .addr(alu_y[AW+1:2]), .be(dmem_rd_wr ? st_be : 4'b0000),
    .wdata(st_data), .rdata(mem_rdata)
  );

  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign f3      = instr[14:12];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign f7      = instr[31:25];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u   = {instr[31:12], 12'b0};
  assign imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign rs1_val = gprs[rs1];
  assign rs2_val = gprs[rs2];
  assign pc4     = pc + 32'd4;
  assign alu_y   = alu_eval(alu_op, alu_a, alu_b);

  always_comb begin
    legal       = 1'b0;
    wr_rd       = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    take        = 1'b0;
    ecall_instr = 1'b0;
    wb_sel      = 2'd0;  // 0: ALU, 1: pc+4, 2: load
    alu_op      = ALU_ADD;
    alu_a       = rs1_val;
    alu_b       = imm_i;
    jump_tgt    = pc + imm_b;
    case (opcode)
      OP_LUI:   begin legal = 1'b1; wr_rd = 1'b1; alu_op = ALU_PASS_B; alu_b = imm_u; end
      OP_AUIPC: begin legal = 1'b1; wr_rd = 1'b1; alu_a = pc; alu_b = imm_u; end
      OP_JAL:   begin
        legal = 1'b1; wr_rd = 1'b1; wb_sel = 2'd1; take = 1'b1; jump_tgt = pc + imm_j;
      end
      OP_JALR:  begin
        legal = (f3 == 3'd0); wr_rd = 1'b1; wb_sel = 2'd1; take = 1'b1;
        jump_tgt = {alu_y[31:1], 1'b0};
      end
      OP_BRANCH: begin
        legal = (f3 != 3'd2) && (f3 != 3'd3);
        case (f3)
          F3_BEQ:  take = (rs1_val == rs2_val);
          F3_BNE:  take = (rs1_val != rs2_val);
          F3_BLT:  take = ($signed(rs1_val) < $signed(rs2_val));
          F3_BGE:  take = ($signed(rs1_val) >= $signed(rs2_val));
          F3_BLTU: take = (rs1_val < rs2_val);
          F3_BGEU: take = (rs1_val >= rs2_val);
          default: take = 1'b0;
        endcase
      end
      OP_LOAD: begin
        legal   = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) || (f3 == F3_LBU) || (f3 == F3_LHU);
        is_load = 1'b1; wr_rd = 1'b1; wb_sel = 2'd2;
      end
      OP_STORE: begin legal = (f3 <= F3_SW); is_store = 1'b1; alu_b = imm_s; end
      OP_IMM, OP_OP: begin
        wr_rd = 1'b1;
        if (opcode == OP_OP) begin
          alu_b = rs2_val;
          legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == F3_ADD) || (f3 == F3_SR)));
        end else if (f3 == F3_SLL) legal = (f7 == 7'h00);
        else if (f3 == F3_SR)      legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                       legal = 1'b1;
        case (f3)
          F3_ADD:  alu_op = (opcode == OP_OP && f7[5]) ? ALU_SUB : ALU_ADD;
          F3_SLL:  alu_op = ALU_SLL;
          F3_SLT:  alu_op = ALU_SLT;
          F3_SLTU: alu_op = ALU_SLTU;
          F3_XOR:  alu_op = ALU_XOR;
          F3_SR:   alu_op = f7[5] ? ALU_SRA : ALU_SRL;
          F3_OR:   alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      OP_SYSTEM: ecall_instr = (instr[31:7] == 25'd0);
      default: ;
    endcase
    // Illegal encodings fall through as NOPs: nothing written, pc+4.
    if (!legal) begin
      wr_rd = 1'b0; is_load = 1'b0; is_store = 1'b0; take = 1'b0;
    end
  end

  always_comb begin
    case (f3)
      F3_LB:   load_val = {{24{mem_rdata[8*alu_y[1:0] + 7]}}, mem_rdata[8*alu_y[1:0] +: 8]};
      F3_LBU:  load_val = {24'b0, mem_rdata[8*alu_y[1:0] +: 8]};
      F3_LH:   load_val = {{16{mem_rdata[16*alu_y[1] + 15]}}, mem_rdata[16*alu_y[1] +: 16]};
      F3_LHU:  load_val = {16'b0, mem_rdata[16*alu_y[1] +: 16]};
      default: load_val = mem_rdata;
    endcase
    case (f3)
      F3_SB:   begin st_data = {4{rs2_val[7:0]}};  st_be = 4'b0001 << alu_y[1:0]; end
      F3_SH:   begin st_data = {2{rs2_val[15:0]}}; st_be = alu_y[1] ? 4'b1100 : 4'b0011; end
      default: begin st_data = rs2_val;            st_be = 4'b1111; end
    endcase
    case (wb_sel)
      2'd1:    wb_data = pc4;
      2'd2:    wb_data = load_val;
      default: wb_data = alu_y;
    endcase
  end

  assign exec         = !rst && !halted && legal;
  assign rf_wr_en     = exec && wr_rd && (rd != 5'd0);
  assign rf_wr_data   = rst ? '0 : wb_data;
  assign rf_wr_addr   = rst ? '0 : rd;
  assign dmem_en      = exec && (is_load || is_store);
  assign dmem_rd_wr   = exec && is_store;
  assign dmem_addr    = rst ? '0 : alu_y;
  assign dmem_wdata   = rst ? '0 : st_data;
  assign dmem_ready   = 1'b1;
  assign branch_taken = !rst && !halted && take;
  assign target_pc    = rst ? '0 : (take ? jump_tgt : pc4);
  assign ecall        = !rst && (halted || ecall_instr);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= BOOT_ADDRESS;
      halted <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) gprs[i] <= '0;
    end else if (!halted) begin
      if (ecall_instr) begin
        halted <= 1'b1;
      end else begin
        pc <= take ? jump_tgt : pc4;
        if (rf_wr_en) gprs[rd] <= rf_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_wiscv_proc.sv
// tb_wiscv_proc: directed program bench for wiscv_proc. Loads small hand-
// assembled programs into instruction memory and checks probes and state
// against hand-computed values.
module tb_wiscv_proc;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  wiscv_proc #(.BOOT_ADDRESS(32'h0000_0000), .MEM_WORDS(4096)) dut (
    .clk(clk),
    .rst(rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input logic [31:0] target);
    int n;
    n = 0;
    while (dut.pc !== target && n < 100) begin
      tick();
      n++;
    end
    check("run_to_pc", dut.pc, target);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;

    // Program A: arithmetic, branches, jumps, shifts/compares, ecall at 0x40
    dut.u_instr_mem.mem[0]  = enc_i(12'd5,   5'd0, 3'd0, 5'd1, 7'h13);  // ADDI x1,x0,5
    dut.u_instr_mem.mem[1]  = enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, 7'h13);  // ADDI x2,x0,-3
    dut.u_instr_mem.mem[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);     // ADD x3,x1,x2
    dut.u_instr_mem.mem[3]  = enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4);     // SUB x4,x2,x1
    dut.u_instr_mem.mem[4]  = enc_i(12'd7,   5'd0, 3'd0, 5'd0, 7'h13);  // ADDI x0,x0,7
    dut.u_instr_mem.mem[5]  = enc_b(13'd8, 5'd1, 5'd1, 3'd0);           // BEQ x1,x1,+8
    dut.u_instr_mem.mem[6]  = enc_i(12'd99,  5'd0, 3'd0, 5'd10, 7'h13); // ADDI x10 (skipped)
    dut.u_instr_mem.mem[7]  = enc_b(13'd8, 5'd1, 5'd2, 3'd6);           // BLTU x2,x1,+8
    dut.u_instr_mem.mem[8]  = enc_j(21'd16, 5'd1);                      // JAL x1,+16
    dut.u_instr_mem.mem[9]  = enc_i(12'd16,  5'd1, 3'd0, 5'd1, 7'h13);  // ADDI x1,x1,16
    dut.u_instr_mem.mem[10] = enc_i(12'h401, 5'd2, 3'd5, 5'd8, 7'h13);  // SRAI x8,x2,1
    dut.u_instr_mem.mem[11] = enc_i(12'h001, 5'd2, 3'd5, 5'd11, 7'h13); // SRLI x11,x2,1
    dut.u_instr_mem.mem[12] = enc_i(12'd0,   5'd1, 3'd0, 5'd0, 7'h67);  // JALR x0,0(x1)
    dut.u_instr_mem.mem[13] = enc_r(7'h00, 5'd3, 5'd2, 3'd2, 5'd9);     // SLT x9,x2,x3
    dut.u_instr_mem.mem[14] = enc_r(7'h00, 5'd3, 5'd2, 3'd3, 5'd12);    // SLTU x12,x2,x3
    dut.u_instr_mem.mem[15] = enc_i(12'd1,   5'd0, 3'd0, 5'd13, 7'h13); // ADDI x13,x0,1
    dut.u_instr_mem.mem[16] = 32'h0000_0073;                            // ECALL

    tick();
    tick();
    check("reset_pc", dut.pc, 32'h0);
    check("reset_gpr1", dut.gprs[1], 32'h0);
    check("reset_wr_en_gated", {31'b0, dut.rf_wr_en}, 32'h0);
    check("reset_ecall", {31'b0, dut.ecall}, 32'h0);
    check("dmem_ready", {31'b0, dut.dmem_ready}, 32'h1);
    rst = 1'b0;
    #1;
    check("addi_wr_en", {31'b0, dut.rf_wr_en}, 32'h1);
    check("addi_wr_data", dut.rf_wr_data, 32'h5);

    run_to(32'h10);
    check("add_x3", dut.gprs[3], 32'h2);
    check("sub_x4", dut.gprs[4], 32'hFFFF_FFF8);
    check("x0_wr_en", {31'b0, dut.rf_wr_en}, 32'h0);
    tick();
    check("x0_stays_zero", dut.gprs[0], 32'h0);
    check("beq_taken", {31'b0, dut.branch_taken}, 32'h1);
    check("beq_target", dut.target_pc, 32'h1C);
    tick();
    check("beq_pc", dut.pc, 32'h1C);
    check("bltu_not_taken", {31'b0, dut.branch_taken}, 32'h0);
    check("bltu_target", dut.target_pc, 32'h20);
    tick();
    check("skipped_x10", dut.gprs[10], 32'h0);
    check("jal_taken", {31'b0, dut.branch_taken}, 32'h1);
    check("jal_target", dut.target_pc, 32'h30);
    tick();
    check("jal_pc", dut.pc, 32'h30);
    check("jal_link", dut.gprs[1], 32'h24);
    tick();
    check("jalr_pc", dut.pc, 32'h24);

    run_to(32'h40);
    check("srai_x8", dut.gprs[8], 32'hFFFF_FFFE);
    check("srli_x11", dut.gprs[11], 32'h7FFF_FFFE);
    check("slt_x9", dut.gprs[9], 32'h1);
    check("sltu_x12", dut.gprs[12], 32'h0);
    check("filler_x13", dut.gprs[13], 32'h1);
    check("ecall_seen", {31'b0, dut.ecall}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_pc", dut.pc, 32'h40);
      check("halt_ecall", {31'b0, dut.ecall}, 32'h1);
      check("halt_no_wr", {31'b0, dut.rf_wr_en}, 32'h0);
    end

    rst = 1'b1;
    tick();
    check("rst2_pc", dut.pc, 32'h0);
    check("rst2_gpr8", dut.gprs[8], 32'h0);

    // Program B: loads/stores, sub-word lanes, FENCE as NOP, ecall
    dut.u_instr_mem.mem[0]  = enc_i(12'd5,   5'd0, 3'd0, 5'd1, 7'h13);  // ADDI x1,x0,5
    dut.u_instr_mem.mem[1]  = enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, 7'h13);  // ADDI x2,x0,-3
    dut.u_instr_mem.mem[2]  = {20'h12345, 5'd5, 7'h37};                 // LUI x5,0x12345
    dut.u_instr_mem.mem[3]  = enc_i(12'h678, 5'd5, 3'd0, 5'd5, 7'h13);  // ADDI x5,x5,0x678
    dut.u_instr_mem.mem[4]  = enc_s(12'h100, 5'd5, 5'd0, 3'd2);         // SW x5,0x100(x0)
    dut.u_instr_mem.mem[5]  = enc_i(12'h101, 5'd0, 3'd0, 5'd6, 7'h03);  // LB x6,0x101(x0)
    dut.u_instr_mem.mem[6]  = enc_i(12'h103, 5'd0, 3'd4, 5'd7, 7'h03);  // LBU x7,0x103(x0)
    dut.u_instr_mem.mem[7]  = enc_s(12'h102, 5'd1, 5'd0, 3'd0);         // SB x1,0x102(x0)
    dut.u_instr_mem.mem[8]  = enc_i(12'h100, 5'd0, 3'd2, 5'd14, 7'h03); // LW x14,0x100(x0)
    dut.u_instr_mem.mem[9]  = enc_s(12'h100, 5'd2, 5'd0, 3'd1);         // SH x2,0x100(x0)
    dut.u_instr_mem.mem[10] = enc_i(12'h100, 5'd0, 3'd1, 5'd15, 7'h03); // LH x15,0x100(x0)
    dut.u_instr_mem.mem[11] = 32'h0000_000F;                            // FENCE
    dut.u_instr_mem.mem[12] = 32'h0000_0073;                            // ECALL

    rst = 1'b0;
    #1;
    check("rst2_ecall_clear", {31'b0, dut.ecall}, 32'h0);

    run_to(32'h10);
    check("sw_dmem_en", {31'b0, dut.dmem_en}, 32'h1);
    check("sw_rd_wr", {31'b0, dut.dmem_rd_wr}, 32'h1);
    check("sw_addr", dut.dmem_addr, 32'h100);
    check("sw_wdata", dut.dmem_wdata, 32'h1234_5678);
    tick();
    check("sw_mem", dut.u_data_mem.mem[64], 32'h1234_5678);
    check("lb_rd_wr", {31'b0, dut.dmem_rd_wr}, 32'h0);
    check("lb_data", dut.rf_wr_data, 32'h56);

    run_to(32'h20);
    check("lb_x6", dut.gprs[6], 32'h56);
    check("lbu_x7", dut.gprs[7], 32'h12);
    check("sb_mem", dut.u_data_mem.mem[64], 32'h1205_5678);
    check("lw_after_sb", dut.rf_wr_data, 32'h1205_5678);

    run_to(32'h2C);
    check("lw_x14", dut.gprs[14], 32'h1205_5678);
    check("sh_mem", dut.u_data_mem.mem[64], 32'h1205_FFFD);
    check("lh_x15", dut.gprs[15], 32'hFFFF_FFFD);
    check("fence_no_wr", {31'b0, dut.rf_wr_en}, 32'h0);
    check("fence_no_mem", {31'b0, dut.dmem_en}, 32'h0);
    check("fence_target", dut.target_pc, 32'h30);
    tick();
    check("b_ecall", {31'b0, dut.ecall}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
